// File: rtl/phaser_scan_pkg.sv
// Shared definitions for the phaser window scanner: state encodings, phaser handshake codes
// and phase bus width selection (VIRTEX6 selects the wide phaser bus).
package phaser_scan_pkg;

`ifdef VIRTEX6
    localparam int MXPHASE_DEF = 11;
`else
    localparam int MXPHASE_DEF = 6;
`endif

    // Phaser dps_sm_vec value that acknowledges a fire request
    localparam logic [2:0] PH_SM_UNFIRE = 3'h6;

    // Sticky readback code left after a handshake timeout
    localparam logic [3:0] SCAN_SM_TIMEOUT = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FIRE   = 4'd1,
        S_WACK   = 4'd2,
        S_UNFIRE = 4'd3,
        S_SETTLE = 4'd4,
        S_DWELL  = 4'd5,
        S_EVAL   = 4'd6,
        S_CALC   = 4'd7,
        S_DONE   = 4'd8,
        S_FAIL   = 4'd9
    } scan_state_t;

endpackage

// File: rtl/phaser_scan_window.sv
// Tracks contiguous runs of good phases and keeps the longest one; ties keep the earliest run.
module phaser_scan_window
    import phaser_scan_pkg::*;
#(
    parameter int MXPHASE = MXPHASE_DEF
) (
    input  logic               clock,
    input  logic               global_reset_n,
    input  logic               clear,
    input  logic               valid,
    input  logic               good,
    input  logic [MXPHASE-1:0] phase,
    output logic [MXPHASE-1:0] best_lo,
    output logic [MXPHASE:0]   best_len
);

    logic [MXPHASE-1:0] cur_lo_reg, cur_lo_next;
    logic [MXPHASE-1:0] best_lo_reg, best_lo_next;
    logic [MXPHASE:0]   cur_len_reg, cur_len_next;
    logic [MXPHASE:0]   best_len_reg, best_len_next;

    always_comb begin
        cur_lo_next   = cur_lo_reg;
        cur_len_next  = cur_len_reg;
        best_lo_next  = best_lo_reg;
        best_len_next = best_len_reg;
        if (clear) begin
            cur_lo_next   = '0;
            cur_len_next  = '0;
            best_lo_next  = '0;
            best_len_next = '0;
        end else if (valid) begin
            if (good) begin
                cur_lo_next  = (cur_len_reg == '0) ? phase : cur_lo_reg;
                cur_len_next = cur_len_reg + 1'b1;
                // Strict compare so an equal-length later run never displaces the first
                if (cur_len_next > best_len_reg) begin
                    best_len_next = cur_len_next;
                    best_lo_next  = cur_lo_next;
                end
            end else begin
                cur_len_next = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            cur_lo_reg   <= '0;
            cur_len_reg  <= '0;
            best_lo_reg  <= '0;
            best_len_reg <= '0;
        end else begin
            cur_lo_reg   <= cur_lo_next;
            cur_len_reg  <= cur_len_next;
            best_lo_reg  <= best_lo_next;
            best_len_reg <= best_len_next;
        end
    end

    assign best_lo  = best_lo_reg;
    assign best_len = best_len_reg;

endmodule

// File: rtl/phaser_scan.sv
// Phase-window scanner driving the DCM phaser: sweeps a phase range, finds the longest error-free
// window and parks the phaser at its centre. Define PHASER_SCAN_TIMEOUT_EN for a handshake timeout.
module phaser_scan
    import phaser_scan_pkg::*;
#(
    parameter int MXPHASE = MXPHASE_DEF,
    parameter int DWELL_W = 16,
    parameter int SETTLE  = 8
`ifdef PHASER_SCAN_TIMEOUT_EN
    ,
    parameter int TMO_W   = 20
`endif
) (
    input  logic               clock,
    input  logic               global_reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [MXPHASE-1:0] phase_min,
    input  logic [MXPHASE-1:0] phase_max,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               err,
    input  logic               ph_busy,
    input  logic [2:0]         ph_sm_vec,
    output logic               ph_fire,
    output logic               ph_reset,
    output logic [MXPHASE-1:0] ph_phase,
    output logic               scan_busy,
    output logic               scan_done,
    output logic               scan_fail,
    output logic [MXPHASE-1:0] win_lo,
    output logic [MXPHASE:0]   win_len,
    output logic [MXPHASE-1:0] best_phase,
    output logic [3:0]         scan_sm_vec
);

    localparam logic [DWELL_W-1:0] SETTLE_LAST = DWELL_W'(SETTLE - 1);

    scan_state_t        state_reg, state_next;
    logic               start_q_reg;
    logic [MXPHASE-1:0] p_reg, p_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic               bad_reg, bad_next;
    logic               centre_reg, centre_next;
    logic               ph_fire_reg, ph_fire_next;
    logic               ph_reset_reg, ph_reset_next;
    logic [MXPHASE-1:0] ph_phase_reg, ph_phase_next;
    logic               scan_busy_reg;
    logic               scan_done_reg, scan_done_next;
    logic               scan_fail_reg, scan_fail_next;
    logic [MXPHASE-1:0] win_lo_reg, win_lo_next;
    logic [MXPHASE:0]   win_len_reg, win_len_next;
    logic [MXPHASE-1:0] best_phase_reg, best_phase_next;
    logic [3:0]         sm_vec_reg;
    logic               tmo_flag_reg, tmo_flag_next;

    logic               start_rise;
    logic [DWELL_W-1:0] dwell_last;
    logic               win_clear, win_valid;
    logic [MXPHASE-1:0] best_lo;
    logic [MXPHASE:0]   best_len;
    logic [MXPHASE-1:0] centre_phase;

`ifdef PHASER_SCAN_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_reg, tmo_next;
`endif

    assign start_rise   = start & ~start_q_reg;
    // A zero dwell still samples one clock
    assign dwell_last   = (dwell == '0) ? '0 : dwell - 1'b1;
    assign centre_phase = MXPHASE'(best_lo + ((best_len - 1'b1) >> 1));

    phaser_scan_window #(.MXPHASE(MXPHASE)) u_window (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .clear          (win_clear),
        .valid          (win_valid),
        .good           (~bad_reg),
        .phase          (p_reg),
        .best_lo        (best_lo),
        .best_len       (best_len)
    );

    always_comb begin
        state_next      = state_reg;
        p_next          = p_reg;
        cnt_next        = cnt_reg;
        bad_next        = bad_reg;
        centre_next     = centre_reg;
        ph_fire_next    = ph_fire_reg;
        ph_reset_next   = 1'b0;
        ph_phase_next   = ph_phase_reg;
        scan_done_next  = scan_done_reg;
        scan_fail_next  = scan_fail_reg;
        win_lo_next     = win_lo_reg;
        win_len_next    = win_len_reg;
        best_phase_next = best_phase_reg;
        tmo_flag_next   = tmo_flag_reg;
        win_clear       = 1'b0;
        win_valid       = 1'b0;
`ifdef PHASER_SCAN_TIMEOUT_EN
        tmo_next        = tmo_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (start_rise) begin
                    scan_done_next = 1'b0;
                    tmo_flag_next  = 1'b0;
                    if (phase_min <= phase_max) begin
                        scan_fail_next = 1'b0;
                        win_clear      = 1'b1;
                        ph_reset_next  = 1'b1;
                        p_next         = phase_min;
                        centre_next    = 1'b0;
                        state_next     = S_FIRE;
                    end else begin
                        scan_fail_next = 1'b1;
                    end
                end
            end
            S_FIRE: begin
                ph_phase_next = p_reg;
                ph_fire_next  = 1'b1;
                state_next    = S_WACK;
            end
            S_WACK: begin
                if (ph_sm_vec == PH_SM_UNFIRE) begin
                    ph_fire_next = 1'b0;
                    state_next   = S_UNFIRE;
                end
            end
            S_UNFIRE: begin
                if (!ph_busy) begin
                    cnt_next   = '0;
                    bad_next   = 1'b0;
                    state_next = centre_reg ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = S_DWELL;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DWELL: begin
                bad_next = bad_reg | err;
                if (cnt_reg == dwell_last) begin
                    state_next = S_EVAL;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_EVAL: begin
                win_valid = 1'b1;
                if (p_reg == phase_max) begin
                    state_next = S_CALC;
                end else begin
                    p_next     = p_reg + 1'b1;
                    state_next = S_FIRE;
                end
            end
            S_CALC: begin
                win_lo_next  = best_lo;
                win_len_next = best_len;
                if (best_len == '0) begin
                    state_next = S_FAIL;
                end else begin
                    best_phase_next = centre_phase;
                    p_next          = centre_phase;
                    centre_next     = 1'b1;
                    state_next      = S_FIRE;
                end
            end
            S_DONE: begin
                scan_done_next = 1'b1;
                state_next     = S_IDLE;
            end
            S_FAIL: begin
                scan_fail_next = 1'b1;
                ph_fire_next   = 1'b0;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

`ifdef PHASER_SCAN_TIMEOUT_EN
        if (state_reg == S_FIRE) begin
            tmo_next = '0;
        end else if (state_reg == S_WACK || state_reg == S_UNFIRE) begin
            if (&tmo_reg) begin
                ph_fire_next  = 1'b0;
                tmo_flag_next = 1'b1;
                state_next    = S_FAIL;
            end else begin
                tmo_next = tmo_reg + 1'b1;
            end
        end
`endif

        // Abort wins over everything and leaves the previous results untouched
        if (abort && state_reg != S_IDLE) begin
            state_next      = S_IDLE;
            ph_fire_next    = 1'b0;
            scan_done_next  = 1'b0;
            scan_fail_next  = 1'b0;
            win_lo_next     = win_lo_reg;
            win_len_next    = win_len_reg;
            best_phase_next = best_phase_reg;
            tmo_flag_next   = tmo_flag_reg;
            win_valid       = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_reg      <= S_IDLE;
            start_q_reg    <= 1'b0;
            p_reg          <= '0;
            cnt_reg        <= '0;
            bad_reg        <= 1'b0;
            centre_reg     <= 1'b0;
            ph_fire_reg    <= 1'b0;
            ph_reset_reg   <= 1'b0;
            ph_phase_reg   <= '0;
            scan_busy_reg  <= 1'b0;
            scan_done_reg  <= 1'b0;
            scan_fail_reg  <= 1'b0;
            win_lo_reg     <= '0;
            win_len_reg    <= '0;
            best_phase_reg <= '0;
            sm_vec_reg     <= '0;
            tmo_flag_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_q_reg    <= start;
            p_reg          <= p_next;
            cnt_reg        <= cnt_next;
            bad_reg        <= bad_next;
            centre_reg     <= centre_next;
            ph_fire_reg    <= ph_fire_next;
            ph_reset_reg   <= ph_reset_next;
            ph_phase_reg   <= ph_phase_next;
            scan_busy_reg  <= (state_next != S_IDLE);
            scan_done_reg  <= scan_done_next;
            scan_fail_reg  <= scan_fail_next;
            win_lo_reg     <= win_lo_next;
            win_len_reg    <= win_len_next;
            best_phase_reg <= best_phase_next;
            sm_vec_reg     <= tmo_flag_next ? SCAN_SM_TIMEOUT : state_next;
            tmo_flag_reg   <= tmo_flag_next;
        end
    end

`ifdef PHASER_SCAN_TIMEOUT_EN
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            tmo_reg <= '0;
        end else begin
            tmo_reg <= tmo_next;
        end
    end
`endif

    assign ph_fire     = ph_fire_reg;
    assign ph_reset    = ph_reset_reg;
    assign ph_phase    = ph_phase_reg;
    assign scan_busy   = scan_busy_reg;
    assign scan_done   = scan_done_reg;
    assign scan_fail   = scan_fail_reg;
    assign win_lo      = win_lo_reg;
    assign win_len     = win_len_reg;
    assign best_phase  = best_phase_reg;
    assign scan_sm_vec = sm_vec_reg;

endmodule
